apb_multi_slave_bridge: RTL

//  - Parametrised APB master bridge that replaces the fixed 2-slave bridge.
//  - Accepts one command at a time on a simple transfer/read_write port.
//  - Decodes the target slave from the upper address bits and runs the APB

---
 rtl/apb_multi_slave_bridge_if.sv | 48 ++++
 rtl/apb_multi_slave_bridge.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/apb_multi_slave_bridge_if.sv
// Command port and APB bus bundle for apb_multi_slave_bridge.
// The master modport is the bridge's view. The slave modport is the view
// of the host plus slave array on the other side of the bridge.
interface apb_multi_slave_bridge_if #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int NS = 4
);
    // Command side: a command is accepted on a cycle where transfer && cmd_ready.
    // The host holds its fields stable on that cycle only. The response is a
    // single-cycle rsp_valid pulse. rsp_error and apb_read_data_out are
    // qualified by that pulse and read as zero otherwise.
    logic                 transfer;
    logic                 read_write;
    logic [AW-1:0]        apb_write_paddr;
    logic [DW-1:0]        apb_write_data;
    logic [DW/8-1:0]      apb_write_strb;
    logic [AW-1:0]        apb_read_paddr;
    logic                 cmd_ready;
    logic [DW-1:0]        apb_read_data_out;
    logic                 rsp_valid;
    logic                 rsp_error;

    // APB side
    logic [NS-1:0]        psel;
    logic                 penable;
    logic                 pwrite;
    logic [AW-1:0]        paddr;
    logic [DW-1:0]        pwdata;
    logic [DW/8-1:0]      pstrb;
    logic [NS*DW-1:0]     prdata;
    logic [NS-1:0]        pready;
    logic [NS-1:0]        pslverr;

    modport master (
        input  transfer, read_write, apb_write_paddr, apb_write_data,
               apb_write_strb, apb_read_paddr, prdata, pready, pslverr,
        output cmd_ready, apb_read_data_out, rsp_valid, rsp_error,
               psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output transfer, read_write, apb_write_paddr, apb_write_data,
               apb_write_strb, apb_read_paddr, prdata, pready, pslverr,
        input  cmd_ready, apb_read_data_out, rsp_valid, rsp_error,
               psel, penable, pwrite, paddr, pwdata, pstrb
    );
endinterface

// File: rtl/apb_multi_slave_bridge.sv
// APB master bridge. It takes one command at a time and decodes the target
// slave from the top address bits. It then runs SETUP/ACCESS on that slave,
// with wait states, PSLVERR propagation and an ACCESS timeout.
module apb_multi_slave_bridge #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int NS     = 4,
    parameter int TO_CYC = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    apb_multi_slave_bridge_if.master  bus,
    output logic [1:0]                dbg_state
);
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int BW = DW / 8;
    localparam int CW = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [BW-1:0]   strb_q;
    logic            write_q;
    logic [SW-1:0]   idx_q;
    logic [CW-1:0]   wait_cnt;
    logic            rsp_valid_q;
    logic            rsp_error_q;
    logic [DW-1:0]   rdata_q;

    logic            accept;
    logic [AW-1:0]   cmd_addr;
    logic [SW-1:0]   cmd_idx;
    logic            cmd_bad;
    logic            sel_ready;
    logic            sel_err;
    logic [DW-1:0]   sel_rdata;
    logic            done;
    logic            timeout;

    // Command decode: the address comes from the port matching the direction
    assign accept   = bus.transfer && (state == IDLE);
    assign cmd_addr = bus.read_write ? bus.apb_read_paddr : bus.apb_write_paddr;
    assign cmd_idx  = cmd_addr[AW-1 -: SW];
    assign cmd_bad  = int'(cmd_idx) >= NS;

    // Pick the response lines of the latched slave; other slaves are ignored
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            if (int'(idx_q) == i) begin
                sel_ready = bus.pready[i];
                sel_err   = bus.pslverr[i];
                sel_rdata = bus.prdata[i*DW +: DW];
            end
        end
    end

    // FSM state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and phase outputs. A bad decode never leaves IDLE.
    always_comb begin
        state_nxt   = state;
        done        = 1'b0;
        timeout     = 1'b0;
        bus.psel    = '0;
        bus.penable = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && !cmd_bad) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.penable = 1'b1;
                if (sel_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == CW'(TO_CYC - 1)) begin
                    // This is the TO_CYC-th ACCESS cycle without PREADY
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        for (int i = 0; i < NS; i++) begin
            if (state != IDLE && int'(idx_q) == i) bus.psel[i] = 1'b1;
        end
    end

    // Command latch, wait counter and the one-cycle response registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            wait_cnt    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rdata_q     <= '0;
            if (accept) begin
                if (cmd_bad) begin
                    // Nothing goes out on the bus; only an error response
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b1;
                end else begin
                    addr_q   <= cmd_addr;
                    wdata_q  <= bus.apb_write_data;
                    strb_q   <= bus.read_write ? '0 : bus.apb_write_strb;
                    write_q  <= !bus.read_write;
                    idx_q    <= cmd_idx;
                    wait_cnt <= '0;
                end
            end
            if (done) begin
                rsp_valid_q <= 1'b1;
                rsp_error_q <= sel_err;
                rdata_q     <= write_q ? '0 : sel_rdata;
            end else if (timeout) begin
                rsp_valid_q <= 1'b1;
                rsp_error_q <= 1'b1;
            end else if (state == ACCESS) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    assign bus.cmd_ready         = (state == IDLE);
    assign bus.paddr             = addr_q;
    assign bus.pwdata            = wdata_q;
    assign bus.pstrb             = strb_q;
    assign bus.pwrite            = write_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_error         = rsp_error_q;
    assign bus.apb_read_data_out = rdata_q;
    assign dbg_state             = state;
endmodule
